bayer_line_buffer: RTL

Three-row line buffer that turns a raster Bayer pixel stream into vertically aligned pixel triplets, one column per accepted beat. It stores the two previous image lines in on-chip memory and presents the column's top, middle and bottom pixels together. It sits directly upstream of the 3x3 column-shift window registers, driving their G13/G23/G33-style column inputs, with a valid qualifier and column/row position.

---
 rtl/bayer_line_buffer.sv | 81 ++++++++
 1 files changed

// File: rtl/bayer_line_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bayer_line_buffer: two line memories turn a raster stream into top/mid/bot   |
// | pixel columns with column/row position.            Revision: 1.0            |
// +-----------------------------------------------------------------------------+
module bayer_line_buffer #(
  parameter int DATA_W = 10,
  parameter int IMG_W  = 640,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_top,
  output logic [DATA_W-1:0] out_mid,
  output logic [DATA_W-1:0] out_bot,
  output logic [COL_W-1:0]  out_col,
  output logic [ROW_W-1:0]  out_row
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = '1;
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(2);

  logic [DATA_W-1:0] line0 [IMG_W];
  logic [DATA_W-1:0] line1 [IMG_W];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic             accept;

  // Start of frame overrides the counters on the very beat it arrives.
  assign accept  = in_valid & ~rst;
  assign eff_col = in_sof ? '0 : col;
  assign eff_row = in_sof ? '0 : row;

  // Read-first memories: the line shifts down one slot per accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1[eff_col] <= line0[eff_col];
      line0[eff_col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_top   <= '0;
      out_mid   <= '0;
      out_bot   <= '0;
      out_col   <= '0;
      out_row   <= '0;
      col       <= '0;
      row       <= '0;
    end else if (in_valid) begin
      out_valid <= (eff_row >= FIRST_ROW);
      out_top   <= line1[eff_col];
      out_mid   <= line0[eff_col];
      out_bot   <= in_data;
      out_col   <= eff_col;
      out_row   <= eff_row;
      if (eff_col == LAST_COL) begin
        col <= '0;
        row <= (eff_row == ROW_MAX) ? eff_row : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
